alu_multiciclo: RTL and testbench

Parametrised, sequential ALU with an iterative RV32M-style multiply/divide unit. It covers the full base integer op set in one registered cycle, and MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over WIDTH iterations. It uses a START/BUSY/VALID handshake so the multi-cycle control unit can stall fetch while a long operation runs. It sits in the execute stage and drives the datapath result bus and branch flag.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/mdu_iterativo.sv | 86 ++++++++
 rtl/alu_multiciclo.sv | 123 ++++++++++++
 tb/tb_alu_multiciclo.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state types for the multi-cycle ALU.
// Also holds the test that decides whether a divide finishes in one cycle.
package alu_pkg;

   typedef enum logic [4:0] {
      OP_ADD    = 5'b00000,
      OP_OR     = 5'b00001,
      OP_AND    = 5'b00010,
      OP_NE     = 5'b00011,
      OP_SLT    = 5'b00100,
      OP_RSV5   = 5'b00101,
      OP_RSV6   = 5'b00110,
      OP_SUB    = 5'b00111,
      OP_SLL    = 5'b01000,
      OP_XOR    = 5'b01001,
      OP_SRL    = 5'b01010,
      OP_LTU    = 5'b01011,
      OP_LUI    = 5'b01100,
      OP_SLTU   = 5'b01101,
      OP_SRA    = 5'b01110,
      OP_EQ     = 5'b01111,
      OP_MUL    = 5'b10000,
      OP_MULH   = 5'b10001,
      OP_MULHSU = 5'b10010,
      OP_MULHU  = 5'b10011,
      OP_DIV    = 5'b10100,
      OP_DIVU   = 5'b10101,
      OP_REM    = 5'b10110,
      OP_REMU   = 5'b10111
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV
   } state_e;

   // Divide by zero and signed overflow have fixed answers, so they skip iteration.
   function automatic logic is_special_div(input logic is_div, input logic y_zero,
                                           input logic div_ovf);
      return is_div && (y_zero || div_ovf);
   endfunction

endpackage

// File: rtl/mdu_iterativo.sv
// Iterative multiply/divide datapath: shift-add multiply, restoring divide,
// one bit per cycle on operand magnitudes, with the sign applied on the last step.
module mdu_iterativo #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             load,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             run,
   output logic             done,
   output logic [WIDTH-1:0] result
);
   localparam int CNT_W = $clog2(WIDTH);

   logic [2:0]         mode_q;
   logic               neg_q;
   logic [WIDTH-1:0]   a_q, hi_q, lo_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               is_div, x_sgn, y_sgn, neg_load;
   logic [WIDTH-1:0]   x_mag, y_mag, hi_n, lo_n, div_val;
   logic [WIDTH:0]     sum, rem_sh;
   logic [2*WIDTH-1:0] prod;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   assign is_div   = mode[2];
   assign x_sgn    = is_div ? !mode[0] : (mode[1:0] == 2'b01 || mode[1:0] == 2'b10);
   assign y_sgn    = is_div ? !mode[0] : (mode[1:0] == 2'b01);
   assign x_mag    = mag(x, x_sgn);
   assign y_mag    = mag(y, y_sgn);
   // Remainder follows the dividend; quotient and product follow the operand signs.
   assign neg_load = (is_div && mode[1]) ? (x_sgn && x[WIDTH-1])
                                         : ((x_sgn && x[WIDTH-1]) ^ (y_sgn && y[WIDTH-1]));

   assign sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
   assign rem_sh = {hi_q, lo_q[WIDTH-1]};

   always_comb begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo_q[WIDTH-1:1]};
      if (mode_q[2]) begin
         if (rem_sh >= {1'b0, a_q}) begin
            hi_n = WIDTH'(rem_sh - {1'b0, a_q});
            lo_n = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_n = rem_sh[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign prod    = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
   assign div_val = neg_q ? -(mode_q[1] ? hi_n : lo_n) : (mode_q[1] ? hi_n : lo_n);
   assign result  = mode_q[2]            ? div_val :
                    (mode_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
   assign done    = run && (cnt_q == '0);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mode_q <= '0;
         neg_q  <= 1'b0;
         a_q    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         cnt_q  <= '0;
      end else if (load) begin
         mode_q <= mode;
         neg_q  <= neg_load;
         a_q    <= is_div ? y_mag : x_mag;
         hi_q   <= '0;
         lo_q   <= is_div ? x_mag : y_mag;
         cnt_q  <= CNT_W'(WIDTH - 1);
      end else if (run) begin
         hi_q <= hi_n;
         lo_q <= lo_n;
         if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/alu_multiciclo.sv
// Execute-stage ALU: single-cycle base ops and special divides, iterative
// RV32M multiply/divide via mdu_iterativo, START/BUSY/VALID handshake.
module alu_multiciclo
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [4:0]       CONTROL,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic             BUSY,
   output logic             VALID,
   output logic [WIDTH-1:0] RESULTADO,
   output logic             ZERO
);
   localparam int               SHAMT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_e             state_q, state_d;
   logic               valid_q, valid_d, zero_q;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [WIDTH-1:0]   base_res, spec_res, quick_res, mdu_res;
   logic [SHAMT_W-1:0] shamt;
   logic               is_m, y_zero, div_ovf, special, iterative;
   logic               mdu_load, mdu_run, mdu_done;

   assign shamt = Y[SHAMT_W-1:0];

   // NOTE: every signal driven here gets a default first, so no latch is inferred.
   always_comb begin
      base_res = '0;
      case (CONTROL)
         OP_ADD:  base_res = X + Y;
         OP_SUB:  base_res = X - Y;
         OP_LUI:  base_res = Y;
         OP_SLT:  base_res = WIDTH'($signed(X) < $signed(Y));
         OP_SLTU: base_res = WIDTH'(X < Y);
         OP_LTU:  base_res = WIDTH'(X < Y);
         OP_AND:  base_res = X & Y;
         OP_OR:   base_res = X | Y;
         OP_XOR:  base_res = X ^ Y;
         OP_SLL:  base_res = X << shamt;
         OP_SRL:  base_res = X >> shamt;
         OP_SRA:  base_res = $signed(X) >>> shamt;
         OP_EQ:   base_res = WIDTH'(X == Y);
         OP_NE:   base_res = WIDTH'(X != Y);
         default: base_res = '0;
      endcase
   end

   assign is_m      = CONTROL[4];
   assign y_zero    = (Y == '0);
   assign div_ovf   = !CONTROL[0] && (X == MIN_NEG) && (Y == '1);
   assign special   = is_special_div(is_m && !CONTROL[3] && CONTROL[2], y_zero, div_ovf);
   assign spec_res  = y_zero ? (CONTROL[1] ? X : '1) : (CONTROL[1] ? '0 : X);
   assign quick_res = !is_m ? base_res : (special ? spec_res : '0);
   assign iterative = is_m && !CONTROL[3] && !special;
   assign mdu_run   = (state_q != IDLE);

   mdu_iterativo #(.WIDTH(WIDTH)) u_mdu (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .load   (mdu_load),
      .mode   (CONTROL[2:0]),
      .x      (X),
      .y      (Y),
      .run    (mdu_run),
      .done   (mdu_done),
      .result (mdu_res)
   );

   always_comb begin
      state_d  = state_q;
      valid_d  = 1'b0;
      res_d    = res_q;
      mdu_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (START) begin
               if (iterative) begin
                  mdu_load = 1'b1;
                  state_d  = CONTROL[2] ? DIV : MUL;
               end else begin
                  valid_d = 1'b1;
                  res_d   = quick_res;
               end
            end
         end
         MUL, DIV: begin
            if (mdu_done) begin
               valid_d = 1'b1;
               res_d   = mdu_res;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         res_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         res_q   <= res_d;
         zero_q  <= (res_d != '0);
      end
   end

   assign BUSY      = mdu_run;
   assign VALID     = valid_q;
   assign RESULTADO = res_q;
   assign ZERO      = zero_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Scoreboard bench for alu_multiciclo: randomized and directed ops against an
// arithmetic reference model, plus a few 16-bit directed cases.
module tb_alu_multiciclo;
   import alu_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n, start;
   logic [4:0]    control;
   logic [W-1:0]  x, y, res;
   logic          busy, valid, zero;

   logic          start16;
   logic [4:0]    ctl16;
   logic [15:0]   x16, y16, res16;
   logic          busy16, valid16, zero16;

   typedef struct {
      logic [W-1:0] res;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   busy_from = 0;
   int   busy_to = -1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_multiciclo #(.WIDTH(W)) dut (
      .CLK(clk), .RST_N(rst_n), .START(start), .CONTROL(control), .X(x), .Y(y),
      .BUSY(busy), .VALID(valid), .RESULTADO(res), .ZERO(zero)
   );

   alu_multiciclo #(.WIDTH(16)) dut16 (
      .CLK(clk), .RST_N(rst_n), .START(start16), .CONTROL(ctl16), .X(x16), .Y(y16),
      .BUSY(busy16), .VALID(valid16), .RESULTADO(res16), .ZERO(zero16)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: plain 32/64-bit arithmetic on the operation's definition.
   function automatic void model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output int lat);
      int          ia, ib;
      longint      sa, sbv, ua, ub;
      logic [63:0] p;
      ia = a; ib = b;
      sa = ia; sbv = ib;
      ua = {32'h0, a}; ub = {32'h0, b};
      lat = 1;
      r = '0;
      if (!c[4]) begin
         case (c[3:0])
            4'b0000: r = a + b;
            4'b0111: r = a - b;
            4'b1100: r = b;
            4'b0100: r = (ia < ib) ? 1 : 0;
            4'b1101: r = (a < b) ? 1 : 0;
            4'b0010: r = a & b;
            4'b0001: r = a | b;
            4'b1001: r = a ^ b;
            4'b1000: r = a << b[4:0];
            4'b1010: r = a >> b[4:0];
            4'b1110: r = ia >>> b[4:0];
            4'b1011: r = (a < b) ? 1 : 0;
            4'b1111: r = (a == b) ? 1 : 0;
            4'b0011: r = (a != b) ? 1 : 0;
            default: r = '0;
         endcase
      end else if (!c[3]) begin
         if (c[2]) begin
            if (b == 0) r = c[1] ? a : 32'hFFFF_FFFF;
            else if (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = c[1] ? 32'h0 : a;
            else begin
               lat = W + 1;
               case (c[1:0])
                  2'd0: r = ia / ib;
                  2'd1: r = a / b;
                  2'd2: r = ia % ib;
                  default: r = a % b;
               endcase
            end
         end else begin
            lat = W + 1;
            case (c[1:0])
               2'd0: p = sa * sbv;
               2'd1: p = sa * sbv;
               2'd2: p = sa * ub;
               default: p = ua * ub;
            endcase
            r = (c[1:0] == 2'd0) ? p[31:0] : p[63:32];
         end
      end
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Called at a falling edge; returns at the falling edge after START was sampled.
   task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   lat;
      int   n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         check("busy_timeout", busy, 1'b0);
         return;
      end
      model(c, a, b, e.res, lat);
      e.cyc = cyc + lat;
      if (lat > 1) begin
         busy_from = cyc + 1;
         busy_to   = cyc + W;
      end
      sb.push_back(e);
      start = 1'b1; control = c; x = a; y = b;
      @(negedge clk);
      start = 1'b0; control = 5'($urandom); x = $urandom; y = $urandom;
   endtask

   task automatic run16(input logic [4:0] c, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_r, input int exp_lat);
      int n = 1;
      start16 = 1'b1; ctl16 = c; x16 = a; y16 = b;
      @(negedge clk);
      start16 = 1'b0; x16 = '0; y16 = '0;
      while (!valid16 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("w16_latency", n, exp_lat);
      check("w16_result", res16, exp_r);
      check("w16_zero", zero16, exp_r != 0);
      @(negedge clk);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents VALID.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("busy", busy, (cyc >= busy_from && cyc <= busy_to));
            if (valid) begin
               if (sb.size() == 0) check("spurious_valid", valid, 1'b0);
               else begin
                  e = sb.pop_front();
                  check("valid_cycle", cyc, e.cyc);
                  check("result", res, e.res);
                  check("zero", zero, e.res != 0);
               end
            end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
               e = sb.pop_front();
               check("missing_valid", valid, 1'b1);
            end
         end
      end
   end

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0; control = '0; x = '0; y = '0;
      start16 = 1'b0; ctl16 = '0; x16 = '0; y16 = '0;
      repeat (3) @(negedge clk);
      check("rst_valid", valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_result", res, 32'h0);
      check("rst_zero", zero, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(OP_ADD,   32'd5,          32'd7);
      issue(OP_MULHU, 32'hFFFF_FFFF,  32'd3);
      issue(OP_MUL,   32'hFFFF_FFFF,  32'd3);
      issue(OP_DIV,   32'hFFFF_FFF9,  32'd2);
      issue(OP_REM,   32'hFFFF_FFF9,  32'd2);
      issue(OP_DIVU,  32'd100,        32'd7);
      issue(OP_REMU,  32'd100,        32'd7);
      issue(OP_DIVU,  32'd9,          32'd0);
      issue(OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF);
      issue(OP_REM,   32'h8000_0000,  32'hFFFF_FFFF);
      issue(OP_MULH,  32'hFFFF_FFFE,  32'h7FFF_FFFF);
      issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // START during BUSY must be dropped without a trace.
      issue(OP_DIV, 32'hFFFF_FF9C, 32'd9);
      repeat (4) @(negedge clk);
      start = 1'b1; control = OP_ADD; x = 32'd1; y = 32'd2;
      @(negedge clk);
      start = 1'b0;

      // Asynchronous reset in cycle 10 of a divide aborts it silently.
      issue(OP_DIVU, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_valid", valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_result", res, 32'h0);
      check("midrst_zero", zero, 1'b0);
      sb.delete();
      busy_to = -1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      issue(OP_SUB, 32'd3, 32'd3);
      issue(OP_ADD, 32'd20, 32'd22);
      issue(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
      issue(OP_ADD, 32'hFFFF_FFFF, 32'd1);

      n = 0;
      while (sb.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      run16(OP_SRA,   16'h8000, 16'h0014, 16'hF800, 1);
      run16(OP_SLT,   16'hFFFF, 16'h0001, 16'h0001, 1);
      run16(OP_SLTU,  16'hFFFF, 16'h0001, 16'h0000, 1);
      run16(OP_MULHU, 16'hFFFF, 16'h0003, 16'h0002, 17);
      run16(OP_DIV,   16'hFFF9, 16'h0002, 16'hFFFD, 17);

      for (int i = 0; i < 300; i++) begin
         logic [4:0]  c;
         logic [31:0] a, b;
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: c = 5'($urandom_range(0, 15));
            9:             c = 5'($urandom_range(24, 31));
            default:       c = 5'($urandom_range(16, 23));
         endcase
         a = pick();
         b = ($urandom_range(0, 9) == 0) ? 32'h0 : pick();
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         issue(c, a, b);
      end

      n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb.size(), 0);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
